accel_exec_unit: RTL and testbench

//   Multi-cycle execution stage directly downstream of the accelerator operand/opcode registers.

---
 rtl/accel_exec_unit.sv | 156 +++++++++++++++
 tb/tb_accel_exec_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/accel_exec_unit.sv
// Multi-cycle execution stage: single-cycle ADD/SUB/logic ops, iterative
// shift-add multiply and restoring divide, with a registered 2*WIDTH result.
module accel_exec_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [RW-1:0]     result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    // One iteration step of each algorithm, MSB first (bit index = cnt)
    logic [RW-1:0]     mul_next_c;
    logic [WIDTH:0]    rem_shift_c;
    logic              quo_bit_c;
    logic [WIDTH-1:0]  rem_next_c;

    always_comb begin
        mul_next_c  = {acc_q[RW-2:0], 1'b0} + (b_q[cnt_q] ? RW'(a_q) : RW'(0));
        rem_shift_c = {rem_q, a_q[cnt_q]};
        quo_bit_c   = (rem_shift_c >= {1'b0, b_q});
        rem_next_c  = quo_bit_c ? WIDTH'(rem_shift_c - {1'b0, b_q})
                                : rem_shift_c[WIDTH-1:0];
    end

    // Next-state, datapath and output computation
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        busy_d   = (state_q == ITER);
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = opcode;
                    dbz_d = 1'b0;
                    if (opcode == OP_MUL || opcode == OP_DIV) begin
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        rem_d   = '0;
                        state_d = ITER;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            ITER: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_next_c;
                end else begin
                    rem_d = rem_next_c;
                    acc_d = {acc_q[RW-2:0], quo_bit_c};
                end
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                unique case (op_q)
                    OP_ADD:  result_d = RW'(a_q) + RW'(b_q);
                    OP_SUB:  result_d = RW'(a_q) - RW'(b_q);
                    OP_MUL:  result_d = acc_q;
                    OP_DIV:  result_d = {rem_q, acc_q[WIDTH-1:0]};
                    OP_AND:  result_d = RW'(a_q & b_q);
                    OP_OR:   result_d = RW'(a_q | b_q);
                    OP_XOR:  result_d = RW'(a_q ^ b_q);
                    default: result_d = '0;
                endcase
                dbz_d = (op_q == OP_DIV) && (b_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_accel_exec_unit.sv
// Scoreboard bench for accel_exec_unit: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_accel_exec_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div_by_zero;

    accel_exec_unit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] res;
        logic        dbz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                          input logic [15:0] er, input logic edz);
        exp_t e;
        a      = ta;
        b      = tb_v;
        opcode = top;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        e.res     = er;
        e.dbz     = edz;
        e.acc_cyc = cyc;
        e.lat     = (top == 3'd2 || top == 3'd3) ? 9 : 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int exp_busy);
        int bc;
        bit seen;
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
        end
        chk("done_seen", 32'(seen), 32'(1));
        if (exp_busy >= 0) chk("busy_cycles", 32'(bc), 32'(exp_busy));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        bit saw_done;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        opcode = '0;
        #12;
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_dbz", 32'(div_by_zero), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(8'd200, 8'd100, 3'd0, 16'h012C, 1'b0); wait_done(0);
        launch(8'd3,   8'd5,   3'd1, 16'hFFFE, 1'b0); wait_done(0);
        launch(8'hF0,  8'h3C,  3'd4, 16'h0030, 1'b0); wait_done(0);
        launch(8'hF0,  8'h0F,  3'd5, 16'h00FF, 1'b0); wait_done(0);
        launch(8'hFF,  8'h0F,  3'd6, 16'h00F0, 1'b0); wait_done(0);
        launch(8'h12,  8'h34,  3'd7, 16'h0000, 1'b0); wait_done(0);
        launch(8'hFF,  8'hFF,  3'd0, 16'h01FE, 1'b0); wait_done(0);
        launch(8'd255, 8'd255, 3'd2, 16'hFE01, 1'b0); wait_done(8);
        launch(8'd200, 8'd7,   3'd3, 16'h041C, 1'b0); wait_done(8);
        launch(8'd42,  8'd0,   3'd3, 16'h2AFF, 1'b1); wait_done(8);

        repeat (3) @(negedge clk);
        chk("hold_dbz", 32'(div_by_zero), 32'(1));
        chk("hold_result", 32'(result), 32'(16'h2AFF));

        launch(8'd1,   8'd1,   3'd0, 16'h0002, 1'b0); wait_done(0);
        launch(8'd255, 8'd255, 3'd3, 16'h0001, 1'b0); wait_done(8);
        launch(8'd5,   8'd9,   3'd3, 16'h0500, 1'b0); wait_done(8);

        // A start pulse during ITER must be ignored
        launch(8'd12, 8'd10, 3'd2, 16'h0078, 1'b0);
        repeat (2) @(negedge clk);
        a      = 8'd1;
        b      = 8'd0;
        opcode = 3'd0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(-1);

        // Reset mid-MUL: outputs clear at once and no done follows
        a      = 8'd12;
        b      = 8'd10;
        opcode = 3'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_dbz", 32'(div_by_zero), 32'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_rst", 32'(saw_done), 32'(0));

        launch(8'd7, 8'd8, 3'd0, 16'h000F, 1'b0); wait_done(0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
